// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types for the memory request arbiter: FSM state encoding,
//   transaction owner encoding and the block-offset width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    OWN_I,
    OWN_D,
    OWN_E
  } owner_e;

  // Number of byte-offset bits inside one cache block.
  function automatic int offs_bits(input int block_bits);
    return $clog2(block_bits / 8);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr
//   Two-way round-robin picker for the read requesters.
//   Ports:
//     i_clk, i_rst  clock, synchronous active-high reset
//     i_req[1:0]    request vector (bit 0 = ICache, bit 1 = DCache)
//     i_advance     a read grant from o_grant is being taken this cycle
//     o_grant[1:0]  one-hot grant (all zero when no request)
module mem_arb_rr (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  // 0 favours requester 0, 1 favours requester 1.
  logic r_ptr;

  always_comb begin
    o_grant = 2'b00;
    if (!r_ptr) begin
      o_grant[0] = i_req[0];
      o_grant[1] = i_req[1] & ~i_req[0];
    end else begin
      o_grant[1] = i_req[1];
      o_grant[0] = i_req[0] & ~i_req[1];
    end
  end

  // After a grant, favour whichever reader did not win it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 1'b0;
    end else if (i_advance) begin
      r_ptr <= o_grant[0];
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares the block-wide memory port between ICache refill, DCache refill
//   and DCache eviction. One transaction at a time; evictions win, reads
//   alternate round-robin.
//   Ports:
//     clk_i, rst_i                          clock, synchronous active-high reset
//     ic_req_i/ic_addr_i                    ICache refill request
//     ic_valid_o/ic_addr_o/ic_data_o        ICache refill response (1-cycle pulse)
//     dc_req_i/dc_addr_i                    DCache refill request
//     dc_valid_o/dc_addr_o/dc_data_o        DCache refill response (1-cycle pulse)
//     dc_evict_i/dc_evict_addr_i/_data_i    DCache writeback request
//     dc_evict_ack_o                        writeback done (1-cycle pulse)
//     mem_req_o/mem_we_o/mem_addr_o/_wdata_o  memory request
//     mem_ack_i/mem_rdata_i                 memory completion and read block
//
//   state | meaning
//   IDLE  | sample requests, latch the winner
//   BUSY  | drive the latched request to memory, wait for mem_ack_i
//   RESP  | pulse the owner's response for one cycle
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_BITS  = 32,
  parameter int BLOCK_BITS = 512
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ic_req_i,
  input  logic [ADDR_BITS-1:0]  ic_addr_i,
  output logic                  ic_valid_o,
  output logic [ADDR_BITS-1:0]  ic_addr_o,
  output logic [BLOCK_BITS-1:0] ic_data_o,
  input  logic                  dc_req_i,
  input  logic [ADDR_BITS-1:0]  dc_addr_i,
  output logic                  dc_valid_o,
  output logic [ADDR_BITS-1:0]  dc_addr_o,
  output logic [BLOCK_BITS-1:0] dc_data_o,
  input  logic                  dc_evict_i,
  input  logic [ADDR_BITS-1:0]  dc_evict_addr_i,
  input  logic [BLOCK_BITS-1:0] dc_evict_data_i,
  output logic                  dc_evict_ack_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_BITS-1:0]  mem_addr_o,
  output logic [BLOCK_BITS-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [BLOCK_BITS-1:0] mem_rdata_i
);

  localparam int OFFS = offs_bits(BLOCK_BITS);
  localparam logic [ADDR_BITS-1:0] ALIGN_MASK = {{(ADDR_BITS-OFFS){1'b1}}, {OFFS{1'b0}}};

  state_e                r_state;
  owner_e                r_owner;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [BLOCK_BITS-1:0] r_wdata;
  logic                  r_we;
  logic [BLOCK_BITS-1:0] r_rdata;
  logic                  r_mem_req;
  logic                  r_ic_valid;
  logic                  r_dc_valid;
  logic                  r_evict_ack;

  logic [1:0] w_rd_req;
  logic [1:0] w_grant;
  logic       w_advance;

  assign w_rd_req  = {dc_req_i, ic_req_i};
  // The rr pointer only moves when a read actually wins the port.
  assign w_advance = (r_state == IDLE) && !dc_evict_i && (w_grant != 2'b00);

  mem_arb_rr u_rr (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_req     (w_rd_req),
    .i_advance (w_advance),
    .o_grant   (w_grant)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_owner     <= OWN_I;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_ic_valid  <= 1'b0;
      r_dc_valid  <= 1'b0;
      r_evict_ack <= 1'b0;
    end else begin
      r_ic_valid  <= 1'b0;
      r_dc_valid  <= 1'b0;
      r_evict_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (dc_evict_i) begin
            r_owner   <= OWN_E;
            r_addr    <= dc_evict_addr_i & ALIGN_MASK;
            r_wdata   <= dc_evict_data_i;
            r_we      <= 1'b1;
            r_mem_req <= 1'b1;
            r_state   <= BUSY;
          end else if (w_grant[0]) begin
            r_owner   <= OWN_I;
            r_addr    <= ic_addr_i & ALIGN_MASK;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_mem_req <= 1'b1;
            r_state   <= BUSY;
          end else if (w_grant[1]) begin
            r_owner   <= OWN_D;
            r_addr    <= dc_addr_i & ALIGN_MASK;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_mem_req <= 1'b1;
            r_state   <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            if (!r_we) begin
              r_rdata <= mem_rdata_i;
            end
            r_mem_req <= 1'b0;
            case (r_owner)
              OWN_I:   r_ic_valid  <= 1'b1;
              OWN_D:   r_dc_valid  <= 1'b1;
              OWN_E:   r_evict_ack <= 1'b1;
              default: r_evict_ack <= 1'b0;
            endcase
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_o      = r_mem_req;
  assign mem_we_o       = r_we;
  assign mem_addr_o     = r_addr;
  assign mem_wdata_o    = r_wdata;
  assign ic_valid_o     = r_ic_valid;
  assign dc_valid_o     = r_dc_valid;
  assign dc_evict_ack_o = r_evict_ack;
  assign ic_addr_o      = r_addr;
  assign dc_addr_o      = r_addr;
  // Both read paths share one response register; each side qualifies it
  // with its own valid.
  assign ic_data_o      = r_rdata;
  assign dc_data_o      = r_rdata;

endmodule
